// File: rtl/multi_edge_pulser.sv
// multi_edge_pulser
// Per-channel input conditioning and pulse generation: synchroniser chain,
// debounce filter, selectable edge detector and fixed-width pulse FSM with a
// sticky flag for edges that arrive while a pulse is still being emitted.
// A short priming window after reset seeds the filter from the synchroniser
// so that a level already present at reset release never looks like an edge.
module multi_edge_pulser #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int PULSE_WIDTH = 1,
    parameter int EDGE_MODE   = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic [CHANNELS-1:0] IN,
    output logic [CHANNELS-1:0] OUT,
    output logic [CHANNELS-1:0] MISSED,
    input  logic [CHANNELS-1:0] CLR_MISSED
);

    localparam int DEB   = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
    localparam int CW    = $clog2(DEB + 1);
    localparam int PCW   = $clog2(PULSE_WIDTH + 1);
    localparam int PRIME = SYNC_STAGES + 1;
    localparam int PRW   = $clog2(PRIME + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    logic [PRW-1:0]         prime_q, prime_d;
    logic                   priming;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
    logic [CHANNELS-1:0]    sync_out;

    logic [CHANNELS-1:0]    filt_q, filt_d;
    logic [CHANNELS-1:0]    filt_dly_q, filt_dly_d;
    logic [CW-1:0]          dcnt_q [CHANNELS];
    logic [CW-1:0]          dcnt_d [CHANNELS];

    logic [CHANNELS-1:0]    rise, fall, qual;

    state_t                 state_q [CHANNELS];
    state_t                 state_d [CHANNELS];
    logic [PCW-1:0]         pcnt_q [CHANNELS];
    logic [PCW-1:0]         pcnt_d [CHANNELS];
    logic [CHANNELS-1:0]    out_q, out_d;
    logic [CHANNELS-1:0]    missed_q, missed_d;

    // Priming window: counts the first SYNC_STAGES+1 edges after reset release.
    always_comb begin
        priming = (prime_q != PRW'(PRIME));
        prime_d = priming ? prime_q + PRW'(1) : prime_q;
    end

    // Synchroniser shift: IN enters stage 0, the last stage feeds the filter.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], IN[c]};
            sync_out[c] = sync_q[c][SYNC_STAGES-1];
        end
    end

    // Debounce: a differing level must persist DEB edges before F follows it.
    always_comb begin
        filt_d     = filt_q;
        filt_dly_d = filt_q;
        dcnt_d     = dcnt_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (priming) begin
                filt_d[c]     = sync_out[c];
                filt_dly_d[c] = sync_out[c];
                dcnt_d[c]     = '0;
            end else if (sync_out[c] != filt_q[c]) begin
                if (dcnt_q[c] == CW'(DEB - 1)) begin
                    filt_d[c] = sync_out[c];
                    dcnt_d[c] = '0;
                end else begin
                    dcnt_d[c] = dcnt_q[c] + CW'(1);
                end
            end else begin
                dcnt_d[c] = '0;
            end
        end
    end

    // Edge detection on the filtered level, suppressed while priming.
    always_comb begin
        rise = filt_q & ~filt_dly_q & {CHANNELS{~priming}};
        fall = ~filt_q & filt_dly_q & {CHANNELS{~priming}};
        if (EDGE_MODE == 0) begin
            qual = rise;
        end else if (EDGE_MODE == 1) begin
            qual = fall;
        end else begin
            qual = rise | fall;
        end
    end

    // Pulse FSM next state, output and sticky missed-edge flag per channel.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        out_d    = out_q;
        missed_d = missed_q;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            case (state_q[c])
                IDLE: begin
                    if (qual[c] && EN) begin
                        state_d[c] = PULSE;
                        out_d[c]   = 1'b1;
                        pcnt_d[c]  = PCW'(PULSE_WIDTH - 1);
                    end
                end
                PULSE: begin
                    if (pcnt_q[c] == '0) begin
                        state_d[c] = IDLE;
                        out_d[c]   = 1'b0;
                    end else begin
                        pcnt_d[c] = pcnt_q[c] - PCW'(1);
                    end
                end
                default: begin
                    state_d[c] = IDLE;
                    out_d[c]   = 1'b0;
                end
            endcase

            if ((state_q[c] == PULSE) && qual[c]) begin
                missed_d[c] = 1'b1;
            end else if (CLR_MISSED[c]) begin
                missed_d[c] = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prime_q    <= '0;
            filt_q     <= '0;
            filt_dly_q <= '0;
            out_q      <= '0;
            missed_q   <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sync_q[c]  <= '0;
                dcnt_q[c]  <= '0;
                state_q[c] <= IDLE;
                pcnt_q[c]  <= '0;
            end
        end else begin
            prime_q    <= prime_d;
            filt_q     <= filt_d;
            filt_dly_q <= filt_dly_d;
            out_q      <= out_d;
            missed_q   <= missed_d;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sync_q[c]  <= sync_d[c];
                dcnt_q[c]  <= dcnt_d[c];
                state_q[c] <= state_d[c];
                pcnt_q[c]  <= pcnt_d[c];
            end
        end
    end

    assign OUT    = out_q;
    assign MISSED = missed_q;

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Testbench for multi_edge_pulser: two instances with different parameter
// sets share the stimulus; a behavioural model predicts OUT and MISSED.
module tb_multi_edge_pulser;

    localparam int N  = 4;
    localparam int SA = 2, DA = 4, PA = 1, EA = 0;
    localparam int SB = 3, DB = 1, PB = 3, EB = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         EN  = 1'b1;
    logic [N-1:0] IN  = '0;
    logic [N-1:0] CLR = '0;
    logic [N-1:0] out_a, miss_a, out_b, miss_b;

    multi_edge_pulser #(.CHANNELS(N), .SYNC_STAGES(SA), .DEBOUNCE(DA),
                        .PULSE_WIDTH(PA), .EDGE_MODE(EA)) dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .IN(IN),
        .OUT(out_a), .MISSED(miss_a), .CLR_MISSED(CLR));

    multi_edge_pulser #(.CHANNELS(N), .SYNC_STAGES(SB), .DEBOUNCE(DB),
                        .PULSE_WIDTH(PB), .EDGE_MODE(EB)) dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .IN(IN),
        .OUT(out_b), .MISSED(miss_b), .CLR_MISSED(CLR));

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model parameters per instance.
    int p_sync[2], p_deb[2], p_pw[2], p_em[2];

    // Model state: samples of IN since reset release, filtered levels,
    // run lengths of disagreement, remaining pulse cycles, missed flags.
    int           ecount;
    logic [N-1:0] samp [0:8191];
    int           mF   [2][N];
    int           mFd  [2][N];
    int           mrun [2][N];
    int           mrem [2][N];
    bit           mmiss[2][N];

    int           pulses[2][N];
    int           highs [2][N];
    logic [N-1:0] prev_a = '0, prev_b = '0;

    task automatic model_reset();
        ecount = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                mF[k][c] = 0; mFd[k][c] = 0; mrun[k][c] = 0;
                mrem[k][c] = 0; mmiss[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        int d, rise, fall, qe;
        ecount++;
        if (ecount < 8192) samp[ecount] = IN;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                // Level seen by the filter: IN as sampled p_sync edges earlier.
                d = (ecount - p_sync[k] >= 1) ? int'(samp[ecount - p_sync[k]][c]) : 0;
                if (ecount <= p_sync[k] + 1) begin
                    mF[k][c] = d; mFd[k][c] = d; mrun[k][c] = 0; qe = 0;
                end else begin
                    rise = int'(mF[k][c] == 1 && mFd[k][c] == 0);
                    fall = int'(mF[k][c] == 0 && mFd[k][c] == 1);
                    qe = (p_em[k] == 0) ? rise : (p_em[k] == 1) ? fall : (rise | fall);
                    mFd[k][c] = mF[k][c];
                    if (d != mF[k][c]) begin
                        mrun[k][c]++;
                        if (mrun[k][c] >= p_deb[k]) begin
                            mF[k][c] = d; mrun[k][c] = 0;
                        end
                    end else begin
                        mrun[k][c] = 0;
                    end
                end
                if (mrem[k][c] > 0) begin
                    if (qe != 0) mmiss[k][c] = 1'b1;
                    else if (CLR[c]) mmiss[k][c] = 1'b0;
                    mrem[k][c]--;
                end else begin
                    if (CLR[c]) mmiss[k][c] = 1'b0;
                    if (qe != 0 && EN) mrem[k][c] = p_pw[k];
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_out(int k);
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = (mrem[k][c] > 0);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_miss(int k);
        logic [N-1:0] r;
        for (int c = 0; c < N; c++) r[c] = mmiss[k][c];
        return r;
    endfunction

    task automatic chk(string tag, logic [N-1:0] got, logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_trk();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N; c++) begin
                pulses[k][c] = 0; highs[k][c] = 0;
            end
    endtask

    // One clock: model advances on the posedge, outputs compared on the negedge.
    task automatic step();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        @(negedge CLK);
        cyc++;
        chk("out_a", out_a, exp_out(0));
        chk("miss_a", miss_a, exp_miss(0));
        chk("out_b", out_b, exp_out(1));
        chk("miss_b", miss_b, exp_miss(1));
        for (int c = 0; c < N; c++) begin
            if (out_a[c]) highs[0][c]++;
            if (out_a[c] && !prev_a[c]) pulses[0][c]++;
            if (out_b[c]) highs[1][c]++;
            if (out_b[c] && !prev_b[c]) pulses[1][c]++;
        end
        prev_a = out_a;
        prev_b = out_b;
    endtask

    initial begin
        int first_a, first_b;
        int hold[N];

        p_sync = '{SA, SB};
        p_deb  = '{(DA < 1) ? 1 : DA, (DB < 1) ? 1 : DB};
        p_pw   = '{PA, PB};
        p_em   = '{EA, EB};
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_out_a", out_a, '0);
        chk("rst_out_b", out_b, '0);

        // Test 1: single rising edge on IN[0], latency and width
        RST = 1'b0;
        repeat (6) step();
        clear_trk();
        IN[0] = 1'b1;
        first_a = -1;
        first_b = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (first_a < 0 && out_a[0]) first_a = i;
            if (first_b < 0 && out_b[0]) first_b = i;
        end
        chk_int("t1_latency_a", first_a, 6);
        chk_int("t1_latency_b", first_b, 4);
        chk_int("t1_pulses_a", pulses[0][0], 1);
        chk_int("t1_width_a", highs[0][0], 1);
        chk_int("t1_others_a", pulses[0][1] + pulses[0][2] + pulses[0][3], 0);
        IN[0] = 1'b0;
        repeat (20) step();

        // Test 2: IN[1] high through reset release
        IN[1] = 1'b1;
        RST = 1'b1;
        repeat (3) step();
        RST = 1'b0;
        clear_trk();
        repeat (20) step();
        chk_int("t2_prime_a", pulses[0][1], 0);
        chk_int("t2_prime_b", pulses[1][1], 0);
        IN[1] = 1'b0;
        repeat (10) step();
        IN[1] = 1'b1;
        repeat (10) step();
        chk_int("t2_pulse_a", pulses[0][1], 1);
        chk_int("t2_pulse_b", pulses[1][1], 2);
        IN[1] = 1'b0;
        repeat (10) step();

        // Test 3: glitches on IN[2] against DEBOUNCE=4
        clear_trk();
        for (int len = 1; len <= 3; len++) begin
            IN[2] = 1'b1;
            repeat (len) step();
            IN[2] = 1'b0;
            repeat (10) step();
        end
        chk_int("t3_short_glitch_a", pulses[0][2], 0);
        IN[2] = 1'b1;
        repeat (4) step();
        IN[2] = 1'b0;
        repeat (15) step();
        chk_int("t3_accept_a", pulses[0][2], 1);

        // Test 4: both-edge instance, width 3, missed edge and clear
        clear_trk();
        IN[0] = 1'b1;
        repeat (8) step();
        IN[0] = 1'b0;
        repeat (12) step();
        chk_int("t4_pulses_b", pulses[1][0], 2);
        chk_int("t4_highs_b", highs[1][0], 6);
        chk_int("t4_nomiss_b", int'(miss_b[0]), 0);
        IN[0] = 1'b1;
        step();
        IN[0] = 1'b0;
        repeat (12) step();
        chk_int("t4_gap_pulses_b", pulses[1][0], 3);
        chk_int("t4_miss_b", int'(miss_b[0]), 1);
        CLR[0] = 1'b1;
        step();
        CLR[0] = 1'b0;
        chk_int("t4_clr_b", int'(miss_b[0]), 0);

        // Test 5: EN gating
        EN = 1'b0;
        clear_trk();
        IN[3] = 1'b1;
        repeat (12) step();
        IN[3] = 1'b0;
        repeat (12) step();
        chk_int("t5_en0_pulse_b", pulses[1][3], 0);
        chk_int("t5_en0_pulse_a", pulses[0][3], 0);
        chk_int("t5_en0_miss_b", int'(miss_b[3]), 0);
        EN = 1'b1;
        clear_trk();
        IN[3] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_b[3]) break;
        end
        EN = 1'b0;
        repeat (10) step();
        chk_int("t5_full_width_b", highs[1][3], 3);
        EN = 1'b1;
        IN[3] = 1'b0;
        repeat (12) step();

        // Randomised traffic with a reset in the middle
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 10);
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    IN[c] = ~IN[c];
                    hold[c] = $urandom_range(1, 10);
                end else begin
                    hold[c]--;
                end
            end
            EN  = ($urandom_range(0, 9) != 0);
            CLR = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            RST = (i >= 300 && i < 302);
            step();
        end
        EN  = 1'b1;
        CLR = '0;
        IN  = '0;
        repeat (20) step();

        // Test 6: asynchronous reset in the 2nd cycle of a 3-cycle pulse
        IN[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_b[0]) break;
        end
        step();
        chk_int("t6_pre_b", int'(out_b[0]), 1);
        #1 RST = 1'b1;
        model_reset();
        #1;
        chk("t6_async_out_b", out_b, '0);
        chk("t6_async_out_a", out_a, '0);
        chk("t6_async_miss_b", miss_b, '0);
        repeat (2) step();
        RST = 1'b0;
        clear_trk();
        repeat (20) step();
        chk_int("t6_release_a", pulses[0][0], 0);
        chk_int("t6_release_b", pulses[1][0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
